sync_fifo: RTL and testbench

Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides and an occupancy count output. It is the generic buffering element used wherever a stream crosses between producer and consumer logic on the same clock, e.g. the 512-word in/out buffers of the FX2 host-interface model. Both sides follow the FIFOInterface convention: data, valid and ready, with a transfer on any clock edge where valid && ready.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/sync_fifo_ram.sv | 30 +++
 rtl/sync_fifo.sv | 101 ++++++++++
 tb/tb_sync_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO family: depth and occupancy-count width
// derived from the log2-depth parameter.
package fifo_pkg;

    function automatic int fifo_depth(input int m);
        return 32'sd1 << m;
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int fifo_count_width(input int m);
        return m + 32'sd1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: synchronous write port,
// asynchronous (combinational) read port, no reset on the array.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int NB = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [NB-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [NB-1:0] rd_data_o
);

    localparam int DEPTH = fifo_depth(AW);

    logic [NB-1:0] mem_q [0:DEPTH-1];

    // Write port: one word per accepted write handshake.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Optional simulation messages on misuse are enabled by defining SYNC_FIFO_CHECK_EN.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int Nb = 8,
    parameter int M  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Nb-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [Nb-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M:0]    count
);

    localparam int             CW      = fifo_count_width(M);
    localparam logic [CW-1:0]  DEPTH_C = CW'(fifo_depth(M));

    logic [M-1:0]  wr_ptr_q, wr_ptr_d;
    logic [M-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_s;
    logic          rd_s;

    // Ready/valid come only from the registered count, so a full FIFO never
    // writes through on a same-cycle read and an empty one never bypasses.
    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = (count_q != {CW{1'b0}});
    assign wr_s      = in_valid  && in_ready;
    assign rd_s      = out_valid && out_ready;
    assign count     = count_q;

    sync_fifo_ram #(
        .NB (Nb),
        .AW (M)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data)
    );

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + M'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + M'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {M{1'b0}};
            rd_ptr_q <= {M{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SYNC_FIFO_CHECK_EN
    // Misuse messages only; they never influence FIFO state.
    always @(posedge clk) begin
        if (!reset) begin
            if (in_valid && (count_q == DEPTH_C)) begin
                $display("%t %m: write attempted on full", $time);
            end
            if (out_ready && (count_q == {CW{1'b0}})) begin
                $display("%t %m: read attempted on empty", $time);
            end
            if (count_q > DEPTH_C) begin
                $display("%t %m: internal error, count %0d exceeds depth", $time, count_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at Nb=16, M=9 (512 words).
module tb_sync_fifo;

    localparam int NB = 16;
    localparam int M  = 9;
    localparam int D  = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [M:0]    count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [NB-1:0] q[$];

    sync_fifo #(.Nb(NB), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
        @(negedge clk);
        step();
        reset = 1'b0;
        step();
        total_cnt++;
        if (count !== 10'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 10'd1) $display("FAIL single_count: got %0d expected 1", count);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h1234) $display("FAIL single_out_data: got %h expected 1234", out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd0) $display("FAIL single_drain_count: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL single_drain_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0100 + i);
            step();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 10'd5) $display("FAIL mid_pre_count: got %0d expected 5", count);
        else pass_cnt++;
        // Handshakes during reset must be ignored.
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'hFFFF;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd0) $display("FAIL mid_reset_count: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count !== 10'd0) $display("FAIL mid_reset_idle_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            step();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 10'd512) $display("FAIL fill_count: got %0d expected 512", count);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready);
        else pass_cnt++;
        in_valid = 1'b1; in_data = 16'hDEAD;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 10'd512) $display("FAIL overfill_count: got %0d expected 512", count);
        else pass_cnt++;
        for (int i = 0; i < D; i++) begin
            out_ready = 1'b1;
            total_cnt++;
            if (out_data !== 16'(i)) $display("FAIL drain_data[%0d]: got %h expected %h", i, out_data, 16'(i));
            else pass_cnt++;
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd0) $display("FAIL drain_count: got %0d expected 0", count);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL drain_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_empty_both();
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h2000 + i);
            step();
        end
        // Full: read happens, write is refused.
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd511) $display("FAIL full_both_count: got %0d expected 511", count);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h2001) $display("FAIL full_both_head: got %h expected 2001", out_data);
        else pass_cnt++;
        for (int i = 1; i < D; i++) begin
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd0) $display("FAIL full_both_drain_count: got %0d expected 0", count);
        else pass_cnt++;
        // Empty: write happens, read is refused.
        in_valid = 1'b1; in_data = 16'h0AA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 10'd1) $display("FAIL empty_both_count: got %0d expected 1", count);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h0AA5) $display("FAIL empty_both_data: got %h expected 0aa5", out_data);
        else pass_cnt++;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (count !== 10'd0) $display("FAIL empty_both_drain_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        bit wr, rd;
        q.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            in_data = 16'($urandom);
            if (q.size() != 0) begin
                total_cnt++;
                if (out_data !== q[0]) $display("FAIL stream_data[%0d]: got %h expected %h", c, out_data, q[0]);
                else pass_cnt++;
            end
            wr = (q.size() != D);
            rd = (q.size() != 0);
            step();
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(in_data);
            total_cnt++;
            if (count !== 10'd1) $display("FAIL stream_count[%0d]: got %0d expected 1", c, count);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        q.delete();
        total_cnt++;
        if (count !== 10'd0) $display("FAIL stream_end_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit wr, rd;
        int pin, pout;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            // Alternate phases so the FIFO swings between full and empty.
            pin  = ((c / 1500) % 2 == 0) ? 85 : 20;
            pout = ((c / 1500) % 2 == 0) ? 20 : 85;
            in_valid  = ($urandom_range(0, 99) < pin);
            out_ready = ($urandom_range(0, 99) < pout);
            in_data   = 16'($urandom);
            total_cnt++;
            if (count !== 10'(q.size())) $display("FAIL rand_count[%0d]: got %0d expected %0d", c, count, q.size());
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== (q.size() != D)) $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, q.size() != D);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== (q.size() != 0)) $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, out_valid, q.size() != 0);
            else pass_cnt++;
            if (q.size() != 0) begin
                total_cnt++;
                if (out_data !== q[0]) $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, q[0]);
                else pass_cnt++;
            end
            wr = in_valid  && (q.size() != D);
            rd = out_ready && (q.size() != 0);
            step();
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(in_data);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_fill_drain();
        test_full_empty_both();
        test_stream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
